// File: rtl/jtag_scan_master.sv
// jtag_scan_master
//   On-chip JTAG scan sequencer. It takes one command at a time (an IR or
//   DR scan of 1..32 bits), walks the TAP from Run-Test/Idle through the
//   scan and back to Run-Test/Idle, and returns the captured TDO bits.
//   jtck/jtms/jtdi are generated from tclk by an internal divider.
//
//   Parameters
//     DIV        tclk cycles per jtck half-period (>= 1)
//
//   Ports
//     tclk       system clock, rising edge only
//     trst       synchronous active-high reset; aborts any scan and
//                reruns the TAP reset sequence
//     cmd_valid  / cmd_ready   command handshake
//     cmd_ir     1 = IR scan, 0 = DR scan
//     cmd_len    scan length minus one (0..31 -> 1..32 bits)
//     cmd_data   TDI bits, bit 0 shifted first
//     cmd_tlr    (only with JTAG_SCAN_TLR_CMD_EN) run the TAP reset
//                pattern instead of a scan; response data is 0
//     rsp_valid  / rsp_ready   response handshake
//     rsp_data   captured TDO bits, bit i = i-th shifted bit, upper bits 0
//     jtck, jtms, jtdi         TAP outputs
//     jtdo       TAP data out
//
//   Build option: define JTAG_SCAN_TLR_CMD_EN to add the cmd_tlr input.

module jtag_scan_master #(
    parameter int unsigned DIV = 2
) (
    input  logic        tclk,
    input  logic        trst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_ir,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] cmd_data,
`ifdef JTAG_SCAN_TLR_CMD_EN
    input  logic        cmd_tlr,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        jtck,
    output logic        jtms,
    output logic        jtdi,
    input  logic        jtdo
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {INIT, IDLE, SEQ, RESP} state_t;

    state_t state, state_next;

    logic [DW-1:0] div_cnt;
    logic [5:0]    step_cnt;
    logic [4:0]    bit_cnt;
    logic          seq_tlr;     // current sequence is the 5x1,1x0 TAP reset pattern
    logic          seq_ir;
    logic [4:0]    seq_len;
    logic [31:0]   seq_data;

    // step decode
    logic          active;
    logic          phase_end;
    logic          tck_rise;
    logic          tck_fall;
    logic [5:0]    shift_first;
    logic [5:0]    shift_last;
    logic [5:0]    last_step;
    logic [5:0]    step_next;
    logic          seq_done;
    logic          in_shift;
    logic          next_in_shift;
    logic          tms_next;
    logic          accept;

    always_comb begin
        active      = (state == INIT) || (state == SEQ);
        phase_end   = active && (div_cnt == DIV_LAST);
        tck_rise    = phase_end && !jtck;
        tck_fall    = phase_end && jtck;

        // Shift steps start after Select/Capture (plus Select-IR for IR);
        // the last shift step carries TMS=1 into Exit1, then Update, Idle.
        shift_first = seq_ir ? 6'd4 : 6'd3;
        shift_last  = shift_first + {1'b0, seq_len};
        last_step   = seq_tlr ? 6'd5 : (shift_last + 6'd2);
        step_next   = step_cnt + 6'd1;
        seq_done    = tck_fall && (step_cnt == last_step);

        in_shift      = !seq_tlr && (step_cnt >= shift_first) && (step_cnt <= shift_last);
        next_in_shift = !seq_tlr && (step_next >= shift_first) && (step_next <= shift_last);

        if (seq_tlr) begin
            tms_next = (step_next < 6'd5);
        end else begin
            tms_next = (seq_ir && (step_next == 6'd1)) ||
                       (step_next == shift_last) ||
                       (step_next == shift_last + 6'd1);
        end

        accept = (state == IDLE) && cmd_valid;
    end

    // FSM state register
    always_ff @(posedge tclk) begin
        if (trst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            INIT: begin
                if (seq_done) state_next = IDLE;
            end
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = SEQ;
            end
            SEQ: begin
                if (seq_done) state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = INIT;
        endcase
    end

    // TCK generator, TMS/TDI sequencing and TDO capture
    always_ff @(posedge tclk) begin
        if (trst) begin
            div_cnt  <= '0;
            step_cnt <= '0;
            bit_cnt  <= '0;
            seq_tlr  <= 1'b1;
            seq_ir   <= 1'b0;
            seq_len  <= '0;
            seq_data <= '0;
            rsp_data <= '0;
            jtck     <= 1'b0;
            jtms     <= 1'b1;
            jtdi     <= 1'b0;
        end else if (accept) begin
            div_cnt  <= '0;
            step_cnt <= '0;
            bit_cnt  <= '0;
`ifdef JTAG_SCAN_TLR_CMD_EN
            seq_tlr  <= cmd_tlr;
`else
            seq_tlr  <= 1'b0;
`endif
            seq_ir   <= cmd_ir;
            seq_len  <= cmd_len;
            seq_data <= cmd_data;
            rsp_data <= '0;
            jtck     <= 1'b0;
            // first step of every sequence is TMS=1 (Select-DR or TLR walk)
            jtms     <= 1'b1;
            jtdi     <= 1'b0;
        end else if (active) begin
            if (phase_end) begin
                div_cnt <= '0;
                jtck    <= ~jtck;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            // bit_cnt advances on the rising edge so that it already
            // points at the next TDI bit when the falling edge loads jtdi
            if (tck_rise && in_shift) begin
                rsp_data[bit_cnt] <= jtdo;
                bit_cnt           <= bit_cnt + 5'd1;
            end

            if (tck_fall) begin
                if (step_cnt == last_step) begin
                    step_cnt <= '0;
                    jtms     <= 1'b0;
                    jtdi     <= 1'b0;
                end else begin
                    step_cnt <= step_next;
                    jtms     <= tms_next;
                    jtdi     <= next_in_shift ? seq_data[bit_cnt] : 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Testbench for jtag_scan_master with DIV=2 driving a small DTM TAP model
// (6-bit IR, IDCODE 0x1BEEF001 selected at reset, user register 0x3A
// capturing 0x12345678, everything else bypass).

module tb_jtag_scan_master;

    logic        tclk = 1'b0;
    logic        trst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_ir;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_data;
`ifdef JTAG_SCAN_TLR_CMD_EN
    logic        cmd_tlr;
`endif
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        jtck;
    logic        jtms;
    logic        jtdi;
    logic        jtdo;

    int vectors     = 0;
    int miscompares = 0;

    always #5 tclk = ~tclk;

    jtag_scan_master #(.DIV(2)) dut (
        .tclk      (tclk),
        .trst      (trst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ir    (cmd_ir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
`ifdef JTAG_SCAN_TLR_CMD_EN
        .cmd_tlr   (cmd_tlr),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .jtck      (jtck),
        .jtms      (jtms),
        .jtdi      (jtdi),
        .jtdo      (jtdo)
    );

    // ---------------- DTM TAP model ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SDS, CDR, SDR, E1D, PDR, E2D, UDR,
        SIS, CIR, SIR, E1I, PIR, E2I, UIR
    } tap_t;

    localparam logic [5:0]  IR_IDCODE = 6'h01;
    localparam logic [5:0]  IR_USER   = 6'h3A;
    localparam logic [31:0] IDCODE    = 32'h1BEEF001;
    localparam logic [31:0] USER_CAP  = 32'h12345678;

    tap_t        tap = TLR;
    logic [5:0]  ir = IR_IDCODE;
    logic [5:0]  ir_sr = '0;
    logic [31:0] dr_sr = '0;
    logic [31:0] user_upd = '0;
    logic        tdo = 1'b0;
    int          rises = 0;
    logic [31:0] tms_hist = '0;

    assign jtdo = tdo;

    always @(posedge jtck) begin
        rises    <= rises + 1;
        tms_hist <= {tms_hist[30:0], jtms};
        case (tap)
            TLR: ir <= IR_IDCODE;
            CDR: dr_sr <= (ir == IR_IDCODE) ? IDCODE : (ir == IR_USER) ? USER_CAP : 32'h0;
            SDR: dr_sr <= (ir == IR_IDCODE || ir == IR_USER) ? {jtdi, dr_sr[31:1]} : {31'h0, jtdi};
            UDR: if (ir == IR_USER) user_upd <= dr_sr;
            CIR: ir_sr <= 6'b000001;
            SIR: ir_sr <= {jtdi, ir_sr[5:1]};
            UIR: ir <= ir_sr;
            default: ;
        endcase
        case (tap)
            TLR: tap <= jtms ? TLR : RTI;
            RTI: tap <= jtms ? SDS : RTI;
            SDS: tap <= jtms ? SIS : CDR;
            CDR: tap <= jtms ? E1D : SDR;
            SDR: tap <= jtms ? E1D : SDR;
            E1D: tap <= jtms ? UDR : PDR;
            PDR: tap <= jtms ? E2D : PDR;
            E2D: tap <= jtms ? UDR : SDR;
            UDR: tap <= jtms ? SDS : RTI;
            SIS: tap <= jtms ? TLR : CIR;
            CIR: tap <= jtms ? E1I : SIR;
            SIR: tap <= jtms ? E1I : SIR;
            E1I: tap <= jtms ? UIR : PIR;
            PIR: tap <= jtms ? E2I : PIR;
            E2I: tap <= jtms ? UIR : SIR;
            UIR: tap <= jtms ? SDS : RTI;
            default: tap <= TLR;
        endcase
    end

    always @(negedge jtck) begin
        tdo <= (tap == SDR) ? dr_sr[0] : (tap == SIR) ? ir_sr[0] : 1'b0;
    end

    // ---------------- command driver ----------------
    // Called at a tclk negedge. On a timeout rsp comes back as X and
    // lat/edges as -1, so the caller's comparisons report it.
    task automatic do_cmd(input logic ir_scan, input logic [4:0] len, input logic [31:0] data,
                          output logic [31:0] rsp, output int lat, output int edges);
        int n;
        int r0;
        rsp = 'x; lat = -1; edges = -1;
        cmd_ir = ir_scan; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin @(negedge tclk); n++; end
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            $display("timeout waiting for cmd_ready");
            return;
        end
        r0 = rises;
        @(negedge tclk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin @(negedge tclk); lat++; end
        if (!rsp_valid) begin
            lat = -1;
            $display("timeout waiting for rsp_valid");
            return;
        end
        rsp   = rsp_data;
        edges = rises - r0;
        rsp_ready = 1'b1;
        @(negedge tclk);
        rsp_ready = 1'b0;
    endtask

    // Releases trst at a negedge and follows the INIT sequence.
    task automatic run_init(output int n, output int edges, output logic saw_rsp);
        int r0;
        r0 = rises;
        trst = 1'b0;
        n = 0;
        saw_rsp = 1'b0;
        do begin
            @(negedge tclk);
            n++;
            if (rsp_valid) saw_rsp = 1'b1;
        end while (!cmd_ready && n < 200);
        edges = rises - r0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int n, edges;
        logic saw;
        trst = 1'b1;
        repeat (3) @(negedge tclk);
        vectors++;
        if ({cmd_ready, rsp_valid, jtck, jtms, jtdi} !== 5'b00010) begin
            miscompares++;
            $display("FAIL reset_outputs: got {rdy,rv,tck,tms,tdi}=%b want 00010",
                     {cmd_ready, rsp_valid, jtck, jtms, jtdi});
        end
        vectors++;
        if (rsp_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rsp_data: got %h want 00000000", rsp_data);
        end
        run_init(n, edges, saw);
        vectors++;
        if (n !== 24) begin
            miscompares++;
            $display("FAIL init_cycles: got %0d want 24", n);
        end
        vectors++;
        if (edges !== 6) begin
            miscompares++;
            $display("FAIL init_tck_edges: got %0d want 6", edges);
        end
        // newest TMS at bit 0: trace 1,1,1,1,1,0
        vectors++;
        if (tms_hist[5:0] !== 6'b111110) begin
            miscompares++;
            $display("FAIL init_tms_trace: got %b want 111110", tms_hist[5:0]);
        end
        vectors++;
        if ({jtck, jtms, saw} !== 3'b000 || tap !== RTI) begin
            miscompares++;
            $display("FAIL idle_pins: got tck=%b tms=%b rv_seen=%b tap=%0d want 0 0 0 RTI",
                     jtck, jtms, saw, tap);
        end
    endtask

    task automatic test_idcode;
        logic [31:0] rsp;
        int lat, edges;
        do_cmd(1'b0, 5'd31, 32'h0, rsp, lat, edges);
        vectors++;
        if (rsp !== 32'h1BEEF001) begin
            miscompares++;
            $display("FAIL idcode_data: got %h want 1beef001", rsp);
        end
        vectors++;
        if (edges !== 37) begin
            miscompares++;
            $display("FAIL idcode_tck_edges: got %0d want 37", edges);
        end
        // 37 steps * 2 * DIV + 1
        vectors++;
        if (lat !== 149) begin
            miscompares++;
            $display("FAIL idcode_latency: got %0d want 149", lat);
        end
    endtask

    task automatic test_ir_user;
        logic [31:0] rsp;
        int lat, edges;
        do_cmd(1'b1, 5'd5, 32'h0000003A, rsp, lat, edges);
        // IR capture pattern 000001 shifted out LSB first
        vectors++;
        if (rsp !== 32'h00000001) begin
            miscompares++;
            $display("FAIL ir_capture: got %h want 00000001", rsp);
        end
        vectors++;
        if (edges !== 12 || lat !== 49) begin
            miscompares++;
            $display("FAIL ir_timing: got edges=%0d lat=%0d want 12 49", edges, lat);
        end
        do_cmd(1'b0, 5'd31, 32'hCAFEF00D, rsp, lat, edges);
        vectors++;
        if (rsp !== 32'h12345678) begin
            miscompares++;
            $display("FAIL user_capture: got %h want 12345678", rsp);
        end
        vectors++;
        if (user_upd !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL user_tdi_update: got %h want cafef00d", user_upd);
        end
    endtask

    task automatic test_bypass;
        logic [31:0] rsp;
        int lat, edges;
        do_cmd(1'b1, 5'd5, 32'h0000003F, rsp, lat, edges);
        // bypass capture 0 leaves first, then the three 1s shifted in: 0,1,1,1
        do_cmd(1'b0, 5'd3, 32'h0000000F, rsp, lat, edges);
        vectors++;
        if (rsp !== 32'h0000000E) begin
            miscompares++;
            $display("FAIL bypass_data: got %h want 0000000e", rsp);
        end
        vectors++;
        if (edges !== 9 || lat !== 37) begin
            miscompares++;
            $display("FAIL bypass_timing: got edges=%0d lat=%0d want 9 37", edges, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] held;
        int n, r0, bad;
        // first command: bypass, 4 bits of 1 -> 0xE; left unacknowledged
        cmd_ir = 1'b0; cmd_len = 5'd3; cmd_data = 32'hF; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin @(negedge tclk); n++; end
        @(negedge tclk);
        // second command held on the bus: 3 bits, data 101 -> 0,1,0
        cmd_len = 5'd2; cmd_data = 32'h5;
        n = 0;
        while (!rsp_valid && n < 1000) begin @(negedge tclk); n++; end
        held = rsp_data;
        r0 = rises;
        bad = 0;
        repeat (50) begin
            @(negedge tclk);
            if (cmd_ready || !rsp_valid || rsp_data !== held || jtck) bad++;
        end
        vectors++;
        if (held !== 32'h0000000E || bad !== 0) begin
            miscompares++;
            $display("FAIL stall_hold: got data=%h bad_cycles=%0d want 0000000e 0", held, bad);
        end
        vectors++;
        if (rises - r0 !== 0) begin
            miscompares++;
            $display("FAIL stall_tck_edges: got %0d want 0", rises - r0);
        end
        rsp_ready = 1'b1;
        @(negedge tclk);
        rsp_ready = 1'b0;
        vectors++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL release_ready: got rdy=%b rv=%b want 1 0", cmd_ready, rsp_valid);
        end
        @(negedge tclk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 1000) begin @(negedge tclk); n++; end
        vectors++;
        if (rsp_data !== 32'h00000002) begin
            miscompares++;
            $display("FAIL held_cmd_data: got %h want 00000002", rsp_data);
        end
        rsp_ready = 1'b1;
        @(negedge tclk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_trst_abort;
        logic [31:0] rsp;
        int n, r0, lat, edges;
        logic saw;
        cmd_ir = 1'b0; cmd_len = 5'd31; cmd_data = 32'h0; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin @(negedge tclk); n++; end
        r0 = rises;
        @(negedge tclk);
        cmd_valid = 1'b0;
        // rise 14 = step 13 = shift bit 10 (three preamble steps for DR)
        n = 0;
        while (rises - r0 < 14 && n < 1000) begin @(negedge tclk); n++; end
        trst = 1'b1;
        @(negedge tclk);
        vectors++;
        if ({cmd_ready, rsp_valid, jtck, jtms, jtdi} !== 5'b00010 || rsp_data !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_reset_values: got {rdy,rv,tck,tms,tdi}=%b data=%h want 00010 0",
                     {cmd_ready, rsp_valid, jtck, jtms, jtdi}, rsp_data);
        end
        @(negedge tclk);
        run_init(n, edges, saw);
        vectors++;
        if (n !== 24 || edges !== 6 || tms_hist[5:0] !== 6'b111110 || saw !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_init_rerun: got cycles=%0d edges=%0d tms=%b rv_seen=%b want 24 6 111110 0",
                     n, edges, tms_hist[5:0], saw);
        end
        do_cmd(1'b0, 5'd31, 32'h0, rsp, lat, edges);
        vectors++;
        if (rsp !== 32'h1BEEF001) begin
            miscompares++;
            $display("FAIL abort_idcode: got %h want 1beef001", rsp);
        end
    endtask

    initial begin
        trst = 1'b1;
        cmd_valid = 1'b0;
        cmd_ir = 1'b0;
        cmd_len = '0;
        cmd_data = '0;
`ifdef JTAG_SCAN_TLR_CMD_EN
        cmd_tlr = 1'b0;
`endif
        rsp_ready = 1'b0;
        @(negedge tclk);
        test_reset();
        test_idcode();
        test_ir_user();
        test_bypass();
        test_back_to_back();
        test_trst_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion want completion");
        $fatal(1, "global timeout");
    end

endmodule
